// File: rtl/mul_pipe_param.sv
// mul_pipe_param: elastic RV32M/RV64M MUL/MULH/MULHSU/MULHU pipeline with tag, flush and bubble collapsing
module mul_pipe_param #(
    parameter int WD_SIZE     = 32,
    parameter int MUL_STAGES  = 5,
    parameter int TAG_W       = 5,
    parameter int OPCODE_SIZE = 7,
    parameter int FUNCT7_SIZE = 7,
    parameter int FUNCT3_SIZE = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [OPCODE_SIZE-1:0] opcode_i,
    input  logic [FUNCT7_SIZE-1:0] funct7_i,
    input  logic [FUNCT3_SIZE-1:0] funct3_i,
    input  logic [WD_SIZE-1:0]     op1_data_i,
    input  logic [WD_SIZE-1:0]     op2_data_i,
    input  logic [TAG_W-1:0]       tag_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WD_SIZE-1:0]     result_o,
    output logic [TAG_W-1:0]       tag_o,
    output logic                   busy_o
);
    localparam int W = WD_SIZE;
    localparam int N = MUL_STAGES;
    localparam logic [OPCODE_SIZE-1:0] OPCODE_OP = OPCODE_SIZE'(7'b0110011);
    localparam logic [FUNCT7_SIZE-1:0] F7_MULDIV = FUNCT7_SIZE'(7'b0000001);

    if (MUL_STAGES < 2 || MUL_STAGES > 8) begin : g_bad_stages
        $error("mul_pipe_param: MUL_STAGES must be in 2..8");
    end
    if (WD_SIZE != 32 && WD_SIZE != 64) begin : g_bad_width
        $error("mul_pipe_param: WD_SIZE must be 32 or 64");
    end

    logic [N-1:0]              v;
    logic [N:0]                fr;
    logic [N-1:0][TAG_W-1:0]   t;
    logic [N-1:0]              hi;
    logic [2*W+1:0]            opnd;
    logic [N-1:1][2*W-1:0]     p;
    logic [2*W-1:0]            ax, bx, prod;
    logic                      is_mul, acc, sa, sb;

    // fr[k]: stage k may load this cycle (empty or draining forward)
    always_comb begin
        fr[N] = !valid_o || ready_i;
        for (int k = N - 1; k >= 0; k--) fr[k] = !v[k] || fr[k+1];
    end

    assign is_mul  = opcode_i == OPCODE_OP && funct7_i == F7_MULDIV && funct3_i <= FUNCT3_SIZE'(3);
    assign ready_o = !reset && fr[0];
    assign acc     = valid_i && ready_o && is_mul && !flush_i;
    assign busy_o  = |v || valid_o;
    assign sa      = (funct3_i == FUNCT3_SIZE'(1) || funct3_i == FUNCT3_SIZE'(2)) && op1_data_i[W-1];
    assign sb      = funct3_i == FUNCT3_SIZE'(1) && op2_data_i[W-1];

    // low 2W bits of the sign-extended product are all any result needs
    assign ax   = {{(W-1){opnd[2*W+1]}}, opnd[2*W+1:W+1]};
    assign bx   = {{(W-1){opnd[W]}}, opnd[W:0]};
    assign prod = ax * bx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v        <= '0;
            valid_o  <= 1'b0;
            result_o <= '0;
            tag_o    <= '0;
        end else if (flush_i) begin
            v       <= '0;
            valid_o <= 1'b0;
        end else begin
            if (fr[N]) begin
                valid_o <= v[N-1];
                if (v[N-1]) begin
                    result_o <= hi[N-1] ? p[N-1][2*W-1:W] : p[N-1][W-1:0];
                    tag_o    <= t[N-1];
                end
            end
            for (int k = N - 1; k > 0; k--) if (fr[k]) v[k] <= v[k-1];
            if (fr[0]) v[0] <= acc;
        end
    end

    always_ff @(posedge clk) begin
        if (fr[0]) begin
            opnd  <= {sa, op1_data_i, sb, op2_data_i};
            t[0]  <= tag_i;
            hi[0] <= funct3_i != '0;
        end
        if (fr[1]) p[1] <= prod;
        for (int k = 2; k < N; k++) if (fr[k]) p[k] <= p[k-1];
        for (int k = 1; k < N; k++) begin
            if (fr[k]) begin
                t[k]  <= t[k-1];
                hi[k] <= hi[k-1];
            end
        end
    end
endmodule

// File: tb/tb_mul_pipe_param.sv
// tb_mul_pipe_param: randomized and directed checks of mul_pipe_param against a queue-based reference
module tb_mul_pipe_param;
    localparam int W  = 32;
    localparam int N  = 5;
    localparam int TW = 5;

    logic          clk = 0;
    logic          reset;
    logic          valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
    logic [6:0]    opcode_i, funct7_i;
    logic [2:0]    funct3_i;
    logic [W-1:0]  op1_data_i, op2_data_i, result_o;
    logic [TW-1:0] tag_i, tag_o;

    mul_pipe_param #(.WD_SIZE(W), .MUL_STAGES(N), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode_i), .funct7_i(funct7_i), .funct3_i(funct3_i),
        .op1_data_i(op1_data_i), .op2_data_i(op2_data_i), .tag_i(tag_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .tag_o(tag_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  r;
        logic [TW-1:0] t;
        int            c;
    } exp_t;

    exp_t         q[$];
    int           tests = 0, fails = 0, cyc = 0;
    bit           seen = 0, exact_lat = 0, rnd_on = 0;
    logic [W-1:0] cur_exp = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_mul(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0]  x, y;
        logic [127:0] pr;
        x  = {{32{(f3 == 1 || f3 == 2) && a[31]}}, a};
        y  = {{32{f3 == 1 && b[31]}}, b};
        pr = {{64{x[63]}}, x} * {{64{y[63]}}, y};
        return f3 == 0 ? pr[31:0] : pr[63:32];
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: outputs must match the oldest accepted op, in order, held while stalled
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            seen = 0;
        end else begin
            if (valid_o) begin
                if (q.size() == 0) check("spurious_valid_o", valid_o, 0);
                else begin
                    check("result", result_o, q[0].r);
                    check("tag", tag_o, q[0].t);
                    if (!seen) begin
                        if (exact_lat) check("latency", cyc - q[0].c, N);
                        else check("latency_min", (cyc - q[0].c) >= N, 1);
                        seen = 1;
                    end
                    if (ready_i) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
            if (flush_i) begin
                q.delete();
                seen = 0;
            end else if (valid_i && ready_o && opcode_i == 7'h33 && funct7_i == 7'h01 && funct3_i <= 3)
                q.push_back('{cur_exp, tag_i, cyc + 1});
        end
    end

    task automatic drive(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] t, input logic [W-1:0] e);
        opcode_i = 7'h33; funct7_i = 7'h01; funct3_i = f3;
        op1_data_i = a; op2_data_i = b; tag_i = t; cur_exp = e; valid_i = 1;
    endtask

    task automatic wait_acc(input int bound);
        bit ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = ready_o;
            @(posedge clk);
            #1;
        end
        check("accept_timeout", ok, 1);
        valid_i = 0;
    endtask

    task automatic send(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t, input logic [W-1:0] e);
        drive(f3, a, b, t, e);
        wait_acc(200);
    endtask

    task automatic idle(input int n);
        valid_i = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sv;
        reset = 1; valid_i = 0; flush_i = 0; ready_i = 1;
        opcode_i = 0; funct7_i = 0; funct3_i = 0; op1_data_i = 0; op2_data_i = 0; tag_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_o", valid_o, 0);
        check("rst_result_o", result_o, 0);
        check("rst_tag_o", tag_o, 0);
        check("rst_busy_o", busy_o, 0);
        check("rst_ready_o", ready_o, 0);
        @(posedge clk); #1; reset = 0;
        idle(2);

        exact_lat = 1;
        send(0, 7, 6, 3, 42);
        idle(N + 3);
        send(1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000);
        send(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
        send(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFF);
        send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 32'h0000_0001);
        idle(N + 3);
        for (int i = 0; i < 8; i++) send(0, i, 3, i, i * 3);
        idle(N + 3);

        exact_lat = 0;
        ready_i = 0;
        send(0, 10, 10, 10, 100);
        send(0, 11, 11, 11, 121);
        idle(1);
        for (int i = 0; i < N - 1; i++) send(0, 20 + i, 2, 12 + i, (20 + i) * 2);
        @(negedge clk);
        check("stall_ready_o", ready_o, 0);
        check("stall_busy_o", busy_o, 1);
        @(posedge clk); #1;
        drive(0, 30, 3, 30, 90);
        repeat (3) begin
            @(negedge clk);
            check("stall_hold_ready_o", ready_o, 0);
            @(posedge clk); #1;
        end
        ready_i = 1;
        wait_acc(200);
        idle(N + 4);
        check("stall_drain", q.size(), 0);

        exact_lat = 1;
        send(0, 2, 2, 20, 4);
        send(0, 3, 3, 21, 9);
        send(0, 4, 4, 22, 16);
        drive(0, 5, 5, 23, 25);
        flush_i = 1;
        @(posedge clk); #1;
        flush_i = 0;
        drive(0, 9, 9, 24, 81);
        @(negedge clk);
        check("flush_busy_o", busy_o, 0);
        check("flush_valid_o", valid_o, 0);
        check("flush_ready_o", ready_o, 1);
        @(posedge clk); #1;
        idle(N + 3);

        opcode_i = 7'h33; funct7_i = 7'h01; funct3_i = 4; valid_i = 1;
        repeat (3) begin
            @(negedge clk);
            check("div_ready_o", ready_o, 1);
            check("div_busy_o", busy_o, 0);
            @(posedge clk); #1;
        end
        funct7_i = 7'h00; funct3_i = 0;
        @(posedge clk); #1;
        idle(N + 3);
        check("div_busy_after", busy_o, 0);

        exact_lat = 0;
        ready_i = 0;
        send(0, 5, 5, 7, 25);
        send(3, 32'hFFFF_FFFF, 2, 8, 1);
        sv = 0;
        for (int i = 0; i < 20 && !sv; i++) begin
            @(negedge clk);
            sv = valid_o;
        end
        check("prerst_valid_o", sv, 1);
        @(posedge clk); #3;
        reset = 1;
        #1;
        check("arst_valid_o", valid_o, 0);
        check("arst_result_o", result_o, 0);
        check("arst_tag_o", tag_o, 0);
        check("arst_busy_o", busy_o, 0);
        repeat (2) @(posedge clk);
        #1; reset = 0; ready_i = 1;
        idle(N + 4);
        check("arst_busy_after", busy_o, 0);

        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk); #1;
                ready_i = $urandom_range(0, 3) != 0;
            end
            begin
                for (int i = 0; i < 120; i++) begin
                    logic [2:0]   f3;
                    logic [W-1:0] a, b;
                    f3 = 3'($urandom_range(0, 3));
                    a  = pick();
                    b  = pick();
                    if ($urandom_range(0, 4) == 0) idle(1);
                    send(f3, a, b, TW'(i), ref_mul(f3, a, b));
                end
                idle(1);
                rnd_on = 0;
            end
        join
        @(posedge clk); #2;
        ready_i = 1;
        idle(N + 6);
        check("final_drain", q.size(), 0);
        check("final_busy_o", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_pipe_param.md
Name: mul_pipe_param

Overview:
- Parametrised, fully pipelined RV32M/RV64M multiplier for the execute stage.
- Supports MUL, MULH, MULHSU and MULHU with configurable depth and operand width.
- Uses a valid/ready handshake with per-stage backpressure and bubble collapsing, carries a destination tag, and supports a pipeline flush.
- Sits beside the ALU; results return in order to the writeback arbiter.

Parameters:
- WD_SIZE, 32, operand and result width in bits (32 or 64).
- MUL_STAGES, 5, pipeline depth (latency in cycles); legal range 2..8. Elaboration error outside this range.
- TAG_W, 5, width of the destination tag carried alongside each operation.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  request valid.
- ready_o  output  1  block can accept this cycle (combinational).
- opcode_i  input  OPCODE_SIZE  instruction opcode.
- funct7_i  input  FUNCT7_SIZE  instruction funct7.
- funct3_i  input  FUNCT3_SIZE  instruction funct3; selects MUL=0, MULH=1, MULHSU=2, MULHU=3.
- op1_data_i  input  WD_SIZE  rs1 value.
- op2_data_i  input  WD_SIZE  rs2 value.
- tag_i  input  TAG_W  destination tag.
- flush_i  input  1  kill all in-flight operations.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- result_o  output  WD_SIZE  result.
- tag_o  output  TAG_W  tag of the result.
- busy_o  output  1  at least one stage occupied.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high. While reset is high, every stage valid bit is 0 and valid_o=0, result_o=0, tag_o=0, busy_o=0, ready_o=0.
- Decode: is_mul = (opcode_i==OPCODE_OP) & (funct7_i==F7_MULDIV) & (funct3_i<=3).
- Accept: an operation is accepted when valid_i & ready_o & is_mul & !flush_i.
  - valid_i with !is_mul is ignored: no entry, no response, ready_o unaffected.
- Pipeline: stages S0..S(MUL_STAGES-1). Each stage holds a valid bit, the operands or partial product, the op type and the tag.
  - Stage k advances when stage k+1 is empty or advancing.
  - The last stage advances when !valid_o | ready_i.
  - ready_o = !S0.valid | S0.advance.
  - Bubbles collapse: an empty stage never blocks the stages behind it.
- Latency: exactly MUL_STAGES cycles from the accept edge to valid_o, when unstalled. Throughput is 1 op per cycle.
- Ordering: results leave strictly in acceptance order; no loss, no duplication.
- Output holding: valid_o, result_o and tag_o stay stable while valid_o & !ready_i. valid_o never drops without a handshake except on flush_i or reset.
- Arithmetic:
  - Operands are extended to WD_SIZE+1 bits: signed for MULH (both operands) and MULHSU (op1 only); zero-extended otherwise.
  - Full product is 2*WD_SIZE+2 bits.
  - MUL returns product[WD_SIZE-1:0]. MULH, MULHSU and MULHU return product[2*WD_SIZE-1:WD_SIZE].
  - The partial-product split across stages is implementation-defined; only the latency and the values above are observable.
- Flush:
  - flush_i high clears every stage valid bit and valid_o at the next edge.
  - A request presented in the same cycle as flush_i is not accepted.
  - Acceptance resumes the cycle after flush_i deasserts.
  - result_o and tag_o keep their last values; only valid_o is cleared.
- busy_o = OR of all stage valid bits and valid_o (registered state only).
- Reset mid-operation: all in-flight work is discarded immediately (asynchronously). No result appears after reset is released.
- Data registers may be left non-reset internally, except result_o and tag_o, which reset to 0.

Test Plan:
- MUL 7*6, tag 3, accepted at cycle t, ready_i=1 -> valid_o=1 at t+MUL_STAGES, result_o=42, tag_o=3. valid_o=0 elsewhere.
- WD_SIZE=32 boundary values:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
- Back-to-back 8 MULs (i*3, tags 0..7), ready_i=1 -> 8 consecutive valid_o cycles, in order, results 0,3,...,21.
- Fill the pipeline, drop ready_i for 3 cycles:
  - Output held stable; ready_o=0 once S0 is full and blocked.
  - After release, all MUL_STAGES+1 results emerge in order, none lost or duplicated.
  - A 1-cycle input bubble during streaming is collapsed under stall.
- Three ops in flight, flush_i for 1 cycle with valid_i=1:
  - None of the 3 ops nor the same-cycle op ever produces valid_o.
  - An op accepted the next cycle returns correctly after MUL_STAGES cycles.
  - busy_o=0 the cycle after the flush.
- DIV (funct3=4) with valid_i=1 -> nothing accepted, no valid_o.
- reset pulsed asynchronously between clock edges with 2 ops in flight -> valid_o, result_o and tag_o become 0 immediately; no output after release.
